// File: rtl/counter_job_arbiter.sv
// Two-way round-robin sequencer for a shared N-bit up/down counter with load.
// Optional JOB_CHECK_EN macro adds a final-count checker driving err_out.
module counter_job_arbiter #(
    parameter int unsigned N = 3,
    parameter int unsigned S = 4
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         req_a_in,
    input  logic         req_b_in,
    input  logic [N-1:0] start_a_in,
    input  logic [N-1:0] start_b_in,
    input  logic         dir_a_in,
    input  logic         dir_b_in,
    input  logic [S-1:0] steps_a_in,
    input  logic [S-1:0] steps_b_in,
    input  logic [N-1:0] count_in,
    output logic         ctr_load_out,
    output logic [N-1:0] ctr_d_out,
    output logic         ctr_up_down_out,
    output logic         grant_a_out,
    output logic         grant_b_out,
    output logic         done_a_out,
    output logic         done_b_out,
    output logic [N-1:0] result_out,
    output logic         busy_out,
    output logic         err_out
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [S-1:0] StepOne = 1;

    state_e       state_q, state_d;
    logic         owner_q, owner_d;  // 1 = requester B
    logic         last_q, last_d;    // last granted, 1 = B
    logic [N-1:0] start_q, start_d;
    logic         dir_q, dir_d;
    logic [S-1:0] steps_q, steps_d;
    logic [S-1:0] remaining_q, remaining_d;
    logic [N-1:0] result_q, result_d;
    logic         done_a_q, done_a_d;
    logic         done_b_q, done_b_d;
    logic         pick_b;

    // B wins alone, or on a tie when A was granted last.
    assign pick_b = req_b_in && (!req_a_in || !last_q);

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        start_d         = start_q;
        dir_d           = dir_q;
        steps_d         = steps_q;
        remaining_d     = remaining_q;
        result_d        = result_q;
        done_a_d        = 1'b0;
        done_b_d        = 1'b0;
        ctr_load_out    = 1'b1;
        ctr_d_out       = count_in;
        ctr_up_down_out = dir_q;
        unique case (state_q)
            StIdle: begin
                if (req_a_in || req_b_in) begin
                    owner_d = pick_b;
                    last_d  = pick_b;
                    start_d = pick_b ? start_b_in : start_a_in;
                    dir_d   = pick_b ? dir_b_in : dir_a_in;
                    steps_d = pick_b ? steps_b_in : steps_a_in;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ctr_d_out   = start_q;
                remaining_d = steps_q;
                state_d     = (steps_q == '0) ? StDone : StRun;
            end
            StRun: begin
                ctr_load_out = 1'b0;
                remaining_d  = remaining_q - StepOne;
                if (remaining_q == StepOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = count_in;
                done_a_d = !owner_q;
                done_b_d = owner_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            start_q     <= '0;
            dir_q       <= 1'b0;
            steps_q     <= '0;
            remaining_q <= '0;
            result_q    <= '0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            start_q     <= start_d;
            dir_q       <= dir_d;
            steps_q     <= steps_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
        end
    end

    assign grant_a_out = (state_q == StLoad) && !owner_q;
    assign grant_b_out = (state_q == StLoad) && owner_q;
    assign done_a_out  = done_a_q;
    assign done_b_out  = done_b_q;
    assign result_out  = result_q;
    assign busy_out    = (state_q != StIdle);

`ifdef JOB_CHECK_EN
    logic [N-1:0] expected_q;
    logic         err_q;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            expected_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == StLoad) begin
                expected_q <= dir_q ? start_q + N'(steps_q) : start_q - N'(steps_q);
            end
            if (state_q == StDone && count_in != expected_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule
